usb_sie_transmitter: RTL and testbench
======================================

# usb_sie_transmitter

Transmit half of the USB serial interface engine, paired with the line-state receiver. It drives the differential pair with SYNC, NRZI-encoded and bit-stuffed packet bytes, and EOP. It also drives host-initiated bus-reset SE0. It sits between the packet-formatting logic (byte handshake) and the transceiver pins, and uses the receiver's `connectState` to choose full-speed or low-speed J/K polarity.

## Interface
- `RESET_LEN`, default 16'd60000: bus-reset SE0 duration, in bit ticks.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `connectState`  in  2  0 = disconnected, 1 = low speed, 2 = full speed; 3 is treated as full speed.
- `bitTick`  in  1  one-clk strobe per USB bit time; line symbols change only on ticks.
- `txByte`  in  8  packet byte, sent LSB first.
- `txByteValid`  in  1  `txByte` is valid.
- `txLast`  in  1  qualifies `txByte` as the final byte of the packet.
- `txByteReady`  out  1  combinational; a byte transfers when `txByteValid & txByteReady`.
- `sendReset`  in  1  request a bus reset; level, sampled in IDLE only.
- `TxWireDataOut`  out  2  {D+, D-}.
- `TxWireOE`  out  1  transceiver output enable.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Line symbols:
  - Full speed: J=2'b10, K=2'b01.
  - Low speed: J=2'b01, K=2'b10.
  - SE0=2'b00.
  - Speed is latched when a packet is accepted and held until return to IDLE.
- States:
  - IDLE:
    - OE=0, out=2'b00.
    - If `connectState`==0: ready=0 and `sendReset` is ignored.
    - Else if `sendReset`: go to RESET_SE0 and clear the tick counter.
    - Else ready=1; on a transfer, load the byte, latch `txLast`, and go to SYNC.
  - SYNC:
    - Sends bits 0000_0001 in order, NRZI-encoded from an initial J.
    - On full speed the wire shows K J K J K J K K.
    - The ones-counter is 1 on exit.
  - DATA:
    - One bit per tick.
    - NRZI rule: 0 toggles the line, 1 holds it.
    - After six consecutive 1s (counting includes the SYNC trailing 1), insert one stuff bit (a toggle) and reset the counter.
    - On the tick that sends bit 7 with no pending stuff bit:
      - If the latched last flag is clear, ready=1 that cycle. A transfer loads the next byte; no valid byte is an underrun, which ends the packet.
      - If the last flag is set, the byte is done.
    - A stuff bit owed after the final data bit is sent before EOP.
  - EOP_SE0: two ticks of SE0.
  - EOP_J: one tick of J.
  - At the next tick, OE drops and the state returns to IDLE.
  - RESET_SE0:
    - OE=1 with SE0 for `RESET_LEN` ticks (16-bit counter).
    - Then one J tick, then IDLE.
- `txByteReady` is 0 in every state and cycle not listed above.
- Simultaneous events:
  - `sendReset` and `txByteValid` together in IDLE: reset wins, ready=0.
  - `sendReset` outside IDLE is ignored.
  - `connectState` changes mid-packet are ignored.
- Reset, at any point including mid-packet:
  - Next cycle: state=IDLE, OE=0, out=2'b00, busy=0, ready per IDLE rules.
  - The ones-counter, bit counter, and shift register are cleared.

## Timing
- Accept-to-wire: OE rises and the first SYNC symbol appears at the first `bitTick` after the accepting clk edge (the accept-cycle tick is not used).
- Outputs are registered and update on the clk edge of a `bitTick` cycle.
- Packet length: N bytes with S stuff bits occupy 8+8N+S+3 ticks with OE high. OE falls on the following tick.
- Next-byte handshake window is exactly one clk, coincident with the bit-7 tick. Upstream must present the byte before then.
- `busy` rises the cycle after acceptance and falls the cycle OE falls.
- Bus reset: OE high for `RESET_LEN`+1 ticks.

## Structure
- Package `usb_sie_pkg`:
  - line-symbol constants J_FS, K_FS, J_LS, K_LS, SE0;
  - connect-state encodings DISCONNECT=0, LOW_SPEED=1, FULL_SPEED=2;
  - transmit state enum;
  - stuff threshold 6.
- Sub-module `usb_tx_nrzi_encoder`: holds the NRZI level and the ones-counter. Inputs are bit, tick, and a clear. Outputs are the encoded level and a stuff-request flag.
- The top level holds the FSM, shift register, bit counter, and reset counter.

## Test plan
- Full speed, single byte 0x00 with `txLast`=1 → 19 ticks of OE: SYNC K J K J K J K K, then J K J K J K J K, then SE0 SE0 J; OE low at tick 20.
- Full speed, single byte 0xFF, last → K×5, stuff J, J J J, SE0 SE0 J; 20 ticks total, one stuff bit.
- Low speed, two bytes 0xA5 then 0x3C (second has `txLast`) → symbols inverted versus full speed; `txByteReady` pulses exactly once during bit 7 of byte 1; 27 ticks.
- Underrun: 0x12 sent with `txLast`=0 and no second valid → EOP follows byte 1 directly; return to IDLE.
- `sendReset` with `RESET_LEN`=4 and `txByteValid` both high in IDLE, full speed → SE0×4, J, OE low; ready stays 0; no SYNC.
- `rst` asserted mid-DATA → next cycle OE=0, out=2'b00, busy=0. A fresh 0x00 packet afterwards matches the first scenario exactly.

Source files
------------

// File: rtl/usb_sie_pkg.sv
// Shared constants and types for the USB SIE transmit path.
package usb_sie_pkg;

  // Line symbols as {D+, D-}
  localparam logic [1:0] J_FS = 2'b10;
  localparam logic [1:0] K_FS = 2'b01;
  localparam logic [1:0] J_LS = 2'b01;
  localparam logic [1:0] K_LS = 2'b10;
  localparam logic [1:0] SE0  = 2'b00;

  // Receiver connect-state encodings (3 behaves as full speed)
  localparam logic [1:0] DISCONNECT = 2'd0;
  localparam logic [1:0] LOW_SPEED  = 2'd1;
  localparam logic [1:0] FULL_SPEED = 2'd2;

  // Consecutive ones that force a stuffed toggle
  localparam logic [2:0] STUFF_THRESH = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J,
    ST_RESET_SE0
  } tx_state_t;

  // Map an NRZI level (1 = J) to the wire pair for the latched speed.
  function automatic logic [1:0] line_sym(input logic ls, input logic j);
    if (ls) return j ? J_LS : K_LS;
    else    return j ? J_FS : K_FS;
  endfunction

endpackage

// File: rtl/usb_tx_nrzi_encoder.sv
// NRZI level tracker with ones counter for bit stuffing.
// Level 1 means J; a 0 bit toggles the level, a 1 bit holds it.
// A stuff bit is simply a 0 bit driven by the caller, which also
// clears the ones counter.
module usb_tx_nrzi_encoder
  import usb_sie_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_bit,
  input  logic i_clr,
  output logic o_level,
  output logic o_stuff_req
);

  logic       r_level;
  logic [2:0] r_ones;

  // Advance the line level and ones count once per encoded bit
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_level <= 1'b1;
      r_ones  <= '0;
    end else if (i_tick) begin
      if (i_bit) begin
        r_ones <= r_ones + 3'd1;
      end else begin
        r_level <= ~r_level;
        r_ones  <= '0;
      end
    end
  end

  assign o_level     = r_level;
  assign o_stuff_req = (r_ones == STUFF_THRESH);

endmodule

// File: rtl/usb_sie_transmitter.sv
// USB SIE transmitter: SYNC, NRZI/bit-stuffed data, EOP and bus-reset SE0.
//
// state        | meaning
// ST_IDLE      | line released, waiting for a byte or a reset request
// ST_SYNC      | next tick sends the next SYNC bit
// ST_DATA      | next tick sends a stuff bit, a data bit, or the first EOP SE0
// ST_EOP_SE0   | SE0 ticks of EOP (r_cnt counts down the remaining ones)
// ST_EOP_J     | one J tick, then OE released on the following tick
// ST_RESET_SE0 | bus-reset SE0, r_cnt counts down RESET_LEN ticks
module usb_sie_transmitter
  import usb_sie_pkg::*;
#(
  parameter logic [15:0] RESET_LEN = 16'd60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] connectState,
  input  logic       bitTick,
  input  logic [7:0] txByte,
  input  logic       txByteValid,
  input  logic       txLast,
  output logic       txByteReady,
  input  logic       sendReset,
  output logic [1:0] TxWireDataOut,
  output logic       TxWireOE,
  output logic       busy
);

  tx_state_t   r_state, w_state_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_bitcnt, w_bitcnt_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_oe, w_oe_nxt;
  logic        r_se0, w_se0_nxt;
  logic        r_last, w_last_nxt;
  logic        r_done, w_done_nxt;
  logic        r_ls, w_ls_nxt;
  logic        w_ready;
  logic        w_enc_tick, w_enc_bit, w_enc_clr;
  logic        w_level, w_stuff_req;

  usb_tx_nrzi_encoder u_nrzi (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (w_enc_tick),
    .i_bit       (w_enc_bit),
    .i_clr       (w_enc_clr),
    .o_level     (w_level),
    .o_stuff_req (w_stuff_req)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Datapath registers: shifter, counters, line controls, latched flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_cnt    <= '0;
      r_oe     <= 1'b0;
      r_se0    <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_ls     <= 1'b0;
    end else begin
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_cnt    <= w_cnt_nxt;
      r_oe     <= w_oe_nxt;
      r_se0    <= w_se0_nxt;
      r_last   <= w_last_nxt;
      r_done   <= w_done_nxt;
      r_ls     <= w_ls_nxt;
    end
  end

  // Next-state, handshake and encoder control; line changes only on bitTick
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_cnt_nxt    = r_cnt;
    w_oe_nxt     = r_oe;
    w_se0_nxt    = r_se0;
    w_last_nxt   = r_last;
    w_done_nxt   = r_done;
    w_ls_nxt     = r_ls;
    w_ready      = 1'b0;
    w_enc_tick   = 1'b0;
    w_enc_bit    = 1'b0;
    w_enc_clr    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_enc_clr  = 1'b1;
        w_oe_nxt   = 1'b0;
        w_se0_nxt  = 1'b0;
        w_done_nxt = 1'b0;
        if (connectState != DISCONNECT) begin
          w_ls_nxt = (connectState == LOW_SPEED);
          if (sendReset) begin
            w_cnt_nxt   = RESET_LEN - 16'd1;
            w_state_nxt = ST_RESET_SE0;
          end else begin
            w_ready = 1'b1;
            if (txByteValid) begin
              w_shift_nxt  = txByte;
              w_last_nxt   = txLast;
              w_bitcnt_nxt = '0;
              w_state_nxt  = ST_SYNC;
            end
          end
        end
      end

      ST_SYNC: begin
        if (bitTick) begin
          w_enc_tick   = 1'b1;
          w_enc_bit    = (r_bitcnt == 3'd7);
          w_oe_nxt     = 1'b1;
          w_se0_nxt    = 1'b0;
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bitTick) begin
          if (w_stuff_req) begin
            // Stuffed toggle; if the packet is finished, two SE0 ticks follow
            w_enc_tick = 1'b1;
            w_enc_bit  = 1'b0;
            if (r_done) begin
              w_cnt_nxt   = 16'd1;
              w_state_nxt = ST_EOP_SE0;
            end
          end else if (r_done) begin
            // This tick is already the first EOP SE0
            w_se0_nxt   = 1'b1;
            w_cnt_nxt   = 16'd0;
            w_state_nxt = ST_EOP_SE0;
          end else begin
            w_enc_tick   = 1'b1;
            w_enc_bit    = r_shift[r_bitcnt];
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (r_last) begin
                w_done_nxt = 1'b1;
              end else begin
                w_ready = 1'b1;
                if (txByteValid) begin
                  w_shift_nxt = txByte;
                  w_last_nxt  = txLast;
                end else begin
                  w_done_nxt = 1'b1;
                end
              end
            end
          end
        end
      end

      ST_EOP_SE0: begin
        if (bitTick) begin
          w_se0_nxt = 1'b1;
          if (r_cnt == 16'd0) begin
            w_cnt_nxt   = 16'd1;
            w_state_nxt = ST_EOP_J;
          end else begin
            w_cnt_nxt = r_cnt - 16'd1;
          end
        end
      end

      ST_RESET_SE0: begin
        if (bitTick) begin
          w_oe_nxt  = 1'b1;
          w_se0_nxt = 1'b1;
          if (r_cnt == 16'd0) begin
            w_cnt_nxt   = 16'd1;
            w_state_nxt = ST_EOP_J;
          end else begin
            w_cnt_nxt = r_cnt - 16'd1;
          end
        end
      end

      ST_EOP_J: begin
        if (bitTick) begin
          w_se0_nxt = 1'b0;
          if (r_cnt != 16'd0) begin
            // Clearing the encoder forces the level to J
            w_enc_clr = 1'b1;
            w_cnt_nxt = 16'd0;
          end else begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign txByteReady   = w_ready;
  assign TxWireOE      = r_oe;
  assign TxWireDataOut = (!r_oe || r_se0) ? SE0 : line_sym(r_ls, w_level);
  assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_sie_transmitter.sv
// Scoreboard bench for usb_sie_transmitter: an independent NRZI/stuffing
// model queues the expected {OE, D+, D-} per bit tick; each tick pops one.
module tb_usb_sie_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] connectState;
  logic       bitTick;
  logic [7:0] txByte;
  logic       txByteValid;
  logic       txLast;
  logic       txByteReady;
  logic       sendReset;
  logic [1:0] TxWireDataOut;
  logic       TxWireOE;
  logic       busy;

  usb_sie_transmitter #(.RESET_LEN(16'd4)) dut (
    .clk           (clk),
    .rst           (rst),
    .connectState  (connectState),
    .bitTick       (bitTick),
    .txByte        (txByte),
    .txByteValid   (txByteValid),
    .txLast        (txLast),
    .txByteReady   (txByteReady),
    .sendReset     (sendReset),
    .TxWireDataOut (TxWireDataOut),
    .TxWireOE      (TxWireOE),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_rdy   = 0;
  int         idx     = 0;
  int         n_bytes = 0;
  bit         underrun = 1'b0;
  logic [7:0] pkt [4];
  logic [2:0] q_exp [$];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] sym(input bit ls, input bit j);
    if (ls) return j ? 2'b01 : 2'b10;
    return j ? 2'b10 : 2'b01;
  endfunction

  // Expected wire symbols for the bytes pkt[0..n-1]
  task automatic model_pkt(input int n, input bit ls);
    bit bits [$];
    bit lvl = 1'b1;
    int ones = 0;
    for (int i = 0; i < 8; i++) bits.push_back(i == 7);
    for (int b = 0; b < n; b++)
      for (int i = 0; i < 8; i++) bits.push_back(pkt[b][i]);
    foreach (bits[k]) begin
      if (bits[k]) ones++;
      else begin lvl = ~lvl; ones = 0; end
      q_exp.push_back({1'b1, sym(ls, lvl)});
      if (ones == 6) begin
        lvl = ~lvl;
        ones = 0;
        q_exp.push_back({1'b1, sym(ls, lvl)});
      end
    end
    q_exp.push_back(3'b100);
    q_exp.push_back(3'b100);
    q_exp.push_back({1'b1, sym(ls, 1'b1)});
    q_exp.push_back(3'b000);
  endtask

  task automatic present_next();
    if (idx < n_bytes) begin
      txByte      = pkt[idx];
      txLast      = (idx == n_bytes - 1) && !underrun;
      txByteValid = 1'b1;
    end else begin
      txByteValid = 1'b0;
      txLast      = 1'b0;
    end
  endtask

  task automatic do_tick();
    bit xfer;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bitTick = 1'b1;
    #1;
    xfer = txByteValid && txByteReady;
    if (busy && txByteReady) n_rdy++;
    @(posedge clk);
    #1;
    bitTick = 1'b0;
    if (xfer) begin
      idx++;
      present_next();
    end
  endtask

  task automatic drain(input string tag);
    int budget = 200;
    logic [2:0] exp;
    while (q_exp.size() > 0 && budget > 0) begin
      do_tick();
      exp = q_exp.pop_front();
      chk_val(tag, {29'd0, TxWireOE, TxWireDataOut}, {29'd0, exp});
      budget--;
    end
    if (q_exp.size() != 0) begin
      chk_val({tag, "_timeout"}, q_exp.size(), 0);
      q_exp.delete();
    end
  endtask

  task automatic send_pkt(input string tag, input int n, input bit ur, input bit ls, input int exp_rdy);
    n_bytes  = n;
    underrun = ur;
    idx      = 0;
    n_rdy    = 0;
    connectState = ls ? 2'd1 : 2'd2;
    model_pkt(n, ls);
    @(negedge clk);
    present_next();
    #1 chk_val({tag, "_idle_rdy"}, txByteReady, 1);
    @(posedge clk);
    #1;
    idx = 1;
    present_next();
    chk_val({tag, "_busy_rise"}, busy, 1);
    chk_val({tag, "_oe_pre_tick"}, TxWireOE, 0);
    drain(tag);
    chk_val({tag, "_busy_fall"}, busy, 0);
    chk_val({tag, "_rdy_pulses"}, n_rdy, exp_rdy);
  endtask

  initial begin
    rst = 1'b1; connectState = 2'd2; bitTick = 1'b0; txByte = 8'h00;
    txByteValid = 1'b0; txLast = 1'b0; sendReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_oe", TxWireOE, 0);
    chk_val("rst_out", TxWireDataOut, 0);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_rdy", txByteReady, 1);
    @(negedge clk) rst = 1'b0;

    // Disconnected: no ready, reset request ignored
    connectState = 2'd0;
    @(negedge clk);
    txByteValid = 1'b1; sendReset = 1'b1;
    #1 chk_val("disc_rdy", txByteReady, 0);
    @(posedge clk);
    #1 chk_val("disc_busy", busy, 0);
    txByteValid = 1'b0; sendReset = 1'b0;

    pkt[0] = 8'h00;
    send_pkt("fs_00", 1, 1'b0, 1'b0, 0);

    pkt[0] = 8'hFF;
    send_pkt("fs_ff", 1, 1'b0, 1'b0, 0);

    pkt[0] = 8'hA5; pkt[1] = 8'h3C;
    send_pkt("ls_a5_3c", 2, 1'b0, 1'b1, 1);

    pkt[0] = 8'h12;
    send_pkt("underrun", 1, 1'b1, 1'b0, 1);

    // Multi-byte full speed with stuffing across a byte boundary
    pkt[0] = 8'hF8; pkt[1] = 8'hFF; pkt[2] = 8'h7E;
    send_pkt("fs_3byte", 3, 1'b0, 1'b0, 2);

    // Bus reset wins over a simultaneous valid byte
    connectState = 2'd2; n_rdy = 0; n_bytes = 0; idx = 0;
    @(negedge clk);
    sendReset = 1'b1; txByteValid = 1'b1; txByte = 8'h00; txLast = 1'b1;
    #1 chk_val("busrst_rdy", txByteReady, 0);
    @(posedge clk);
    #1;
    sendReset = 1'b0; txByteValid = 1'b0;
    chk_val("busrst_busy", busy, 1);
    repeat (4) q_exp.push_back(3'b100);
    q_exp.push_back(3'b110);
    q_exp.push_back(3'b000);
    drain("busrst");
    chk_val("busrst_rdy_pulses", n_rdy, 0);
    chk_val("busrst_busy_fall", busy, 0);

    // Reset mid-DATA, then a clean packet
    pkt[0] = 8'h00; n_bytes = 1; underrun = 1'b0; idx = 0;
    @(negedge clk);
    present_next();
    @(posedge clk);
    #1;
    idx = 1;
    present_next();
    repeat (12) do_tick();
    chk_val("mid_oe", TxWireOE, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    chk_val("mid_rst_oe", TxWireOE, 0);
    chk_val("mid_rst_out", TxWireDataOut, 0);
    chk_val("mid_rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    send_pkt("after_rst", 1, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
